// File: rtl/fact_pkg.sv
// Shared register map, state encoding and default sizing for the factorial accelerator.
package fact_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int N_W_DEF    = 4;
   localparam int N_MAX_DEF  = 12;

   localparam logic [1:0] FACT_N      = 2'd0;
   localparam logic [1:0] FACT_GO     = 2'd1;
   localparam logic [1:0] FACT_STATUS = 2'd2;
   localparam logic [1:0] FACT_RESULT = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } fact_state_e;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per cycle, counting the operand down to 1.
module fact_core
   import fact_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF,
   parameter int N_MAX  = N_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [N_W-1:0]    n_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [DATA_W-1:0] result_o
);

   fact_state_e       state_q;
   logic [N_W-1:0]    cnt_q;
   logic [DATA_W-1:0] result_q;
   logic              done_q;
   logic              err_q;
   logic              overflow_q;
   logic [DATA_W-1:0] product;

   // Truncating to DATA_W is harmless: operands within N_MAX never overflow.
   assign product = result_q * DATA_W'(cnt_q);

   // The overflow verdict is captured at start so later writes to N cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         result_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q    <= MUL;
                  cnt_q      <= n_i;
                  result_q   <= DATA_W'(1);
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  overflow_q <= (int'(n_i) > N_MAX);
               end
            end
            MUL: begin
               if (overflow_q) begin
                  err_q    <= 1'b1;
                  done_q   <= 1'b1;
                  result_q <= '0;
                  state_q  <= IDLE;
               end else if (cnt_q > N_W'(1)) begin
                  result_q <= product;
                  cnt_q    <= cnt_q - N_W'(1);
               end else begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = (state_q == MUL);
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign result_o = result_q;

endmodule

// File: rtl/fact_accel.sv
// Bus-facing wrapper: holds the N operand, decodes GO and muxes read data for the core.
module fact_accel
   import fact_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF,
   parameter int N_MAX  = N_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [1:0]        a,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd,
   output logic              busy
);

   logic [N_W-1:0]    n_q;
   logic              goAccept;
   logic              coreDone;
   logic              coreErr;
   logic [DATA_W-1:0] coreResult;
   logic              unusedWdHigh;

   assign unusedWdHigh = ^wd[DATA_W-1:N_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q <= '0;
      end else if (we && (a == FACT_N)) begin
         n_q <= wd[N_W-1:0];
      end
   end

   // A GO arriving mid-computation is dropped so done/err of the running job survive.
   assign goAccept = we && (a == FACT_GO) && wd[0] && !busy;

   fact_core #(
      .DATA_W (DATA_W),
      .N_W    (N_W),
      .N_MAX  (N_MAX)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .start_i  (goAccept),
      .n_i      (n_q),
      .busy_o   (busy),
      .done_o   (coreDone),
      .err_o    (coreErr),
      .result_o (coreResult)
   );

   always_comb begin
      rd = '0;
      case (a)
         FACT_N:      rd = DATA_W'(n_q);
         FACT_GO:     rd = DATA_W'(busy);
         FACT_STATUS: rd = DATA_W'({coreErr, coreDone});
         FACT_RESULT: rd = coreResult;
         default:     rd = '0;
      endcase
   end

endmodule

// File: tb/tb_fact_accel.sv
// Directed, table-driven bench for the factorial accelerator plus hand-written corner sequences.
module tb_fact_accel;
   import fact_pkg::*;

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        busy;

   int checkCount = 0;
   int failCount  = 0;

   typedef struct {
      logic [3:0]  n;
      int          lat;
      logic [31:0] status;
      logic [31:0] result;
   } vec_t;

   vec_t vecs[8];

   fact_accel dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .a    (a),
      .wd   (wd),
      .rd   (rd),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one bus write for exactly one rising edge; returns 1ns after that edge.
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      a  = addr;
      wd = data;
      we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      wd = '0;
   endtask

   task automatic readReg(input logic [1:0] addr, output logic [31:0] val);
      a = addr;
      #1;
      val = rd;
   endtask

   // Counts edges until STATUS.done rises, and how many samples showed busy high.
   task automatic waitDone(output int cycles, output int busyCycles);
      logic [31:0] s;
      logic [31:0] g;
      cycles     = 0;
      busyCycles = 0;
      readReg(FACT_GO, g);
      if (g[0]) busyCycles++;
      readReg(FACT_STATUS, s);
      while (!s[0] && cycles < 60) begin
         @(posedge clk);
         #1;
         cycles++;
         readReg(FACT_GO, g);
         if (g[0]) busyCycles++;
         readReg(FACT_STATUS, s);
      end
   endtask

   task automatic runVector(input vec_t v);
      logic [31:0] val;
      int          cyc;
      int          bcyc;
      applyStimulus(FACT_N, {28'h0, v.n});
      readReg(FACT_N, val);
      checkOutput($sformatf("n%0d_readback", v.n), val, {28'h0, v.n});
      applyStimulus(FACT_GO, 32'h1);
      readReg(FACT_GO, val);
      checkOutput($sformatf("n%0d_busy_after_go", v.n), val, 32'h1);
      readReg(FACT_STATUS, val);
      checkOutput($sformatf("n%0d_status_cleared", v.n), val, 32'h0);
      waitDone(cyc, bcyc);
      checkOutput($sformatf("n%0d_latency", v.n), 32'(cyc), 32'(v.lat));
      checkOutput($sformatf("n%0d_busy_cycles", v.n), 32'(bcyc), 32'(v.lat));
      readReg(FACT_STATUS, val);
      checkOutput($sformatf("n%0d_status", v.n), val, v.status);
      readReg(FACT_RESULT, val);
      checkOutput($sformatf("n%0d_result", v.n), val, v.result);
      checkOutput($sformatf("n%0d_busy_idle", v.n), {31'h0, busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] val;
      int          cyc;
      int          bcyc;

      vecs[0] = '{n: 4'd5,  lat: 5,  status: 32'h1, result: 32'd120};
      vecs[1] = '{n: 4'd0,  lat: 1,  status: 32'h1, result: 32'd1};
      vecs[2] = '{n: 4'd12, lat: 12, status: 32'h1, result: 32'h1C8CFC00};
      vecs[3] = '{n: 4'd13, lat: 1,  status: 32'h3, result: 32'd0};
      vecs[4] = '{n: 4'd3,  lat: 3,  status: 32'h1, result: 32'd6};
      vecs[5] = '{n: 4'd1,  lat: 1,  status: 32'h1, result: 32'd1};
      vecs[6] = '{n: 4'd7,  lat: 7,  status: 32'h1, result: 32'd5040};
      vecs[7] = '{n: 4'd15, lat: 1,  status: 32'h3, result: 32'd0};

      rst = 1'b1;
      we  = 1'b0;
      a   = '0;
      wd  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      for (int i = 0; i < 4; i++) begin
         readReg(2'(i), val);
         checkOutput($sformatf("reset_rd_off%0d", i), val, 32'h0);
      end
      checkOutput("reset_busy", {31'h0, busy}, 32'h0);

      $display("[TB] table vectors");
      for (int i = 0; i < 8; i++) begin
         runVector(vecs[i]);
      end

      $display("[TB] GO with bit0 clear and writes to read-only offsets");
      applyStimulus(FACT_GO, 32'h2);
      checkOutput("go_bit0_clear_busy", {31'h0, busy}, 32'h0);
      readReg(FACT_STATUS, val);
      checkOutput("go_bit0_clear_status", val, 32'h3);
      applyStimulus(FACT_STATUS, 32'h0);
      readReg(FACT_STATUS, val);
      checkOutput("status_write_ignored", val, 32'h3);
      applyStimulus(FACT_RESULT, 32'hDEADBEEF);
      readReg(FACT_RESULT, val);
      checkOutput("result_write_ignored", val, 32'h0);

      $display("[TB] read during write and N truncation");
      a  = FACT_N;
      wd = 32'hFFFF_FFF9;
      we = 1'b1;
      #1;
      checkOutput("read_during_write_old", rd, 32'hF);
      @(posedge clk);
      #1;
      we = 1'b0;
      readReg(FACT_N, val);
      checkOutput("n_truncated_write", val, 32'h9);

      $display("[TB] N and GO written while busy");
      applyStimulus(FACT_N, 32'd6);
      applyStimulus(FACT_GO, 32'h1);
      @(posedge clk);
      #1;
      applyStimulus(FACT_N, 32'd2);
      applyStimulus(FACT_GO, 32'h1);
      readReg(FACT_N, val);
      checkOutput("busy_n_readback", val, 32'd2);
      checkOutput("busy_go_ignored_busy", {31'h0, busy}, 32'h1);
      readReg(FACT_STATUS, val);
      checkOutput("busy_go_ignored_status", val, 32'h0);
      waitDone(cyc, bcyc);
      checkOutput("busy_remaining_latency", 32'(cyc), 32'd3);
      readReg(FACT_RESULT, val);
      checkOutput("busy_result_720", val, 32'd720);
      applyStimulus(FACT_GO, 32'h1);
      waitDone(cyc, bcyc);
      checkOutput("rerun_n2_latency", 32'(cyc), 32'd2);
      readReg(FACT_RESULT, val);
      checkOutput("rerun_n2_result", val, 32'd2);

      $display("[TB] reset mid-computation");
      applyStimulus(FACT_N, 32'd10);
      applyStimulus(FACT_GO, 32'h1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
      readReg(FACT_STATUS, val);
      checkOutput("midrst_status", val, 32'h0);
      readReg(FACT_RESULT, val);
      checkOutput("midrst_result", val, 32'h0);
      readReg(FACT_N, val);
      checkOutput("midrst_n", val, 32'h0);
      runVector('{n: 4'd4, lat: 4, status: 32'h1, result: 32'd24});

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
